// File: rtl/sram_arbiter_ctrl.sv
// sram_arbiter_ctrl
// Arbitrates one write port and one read port (req/ack) onto an asynchronous
// external SRAM. Every SRAM control output is registered. Each access holds the
// bus for WAIT_CYCLES+1 cycles and is followed by at least one idle cycle.
//
// Ports
//   iCLK, iRST              clock, asynchronous active-high reset
//   iWR_REQ/ADDR/DATA/BE    write request, held stable until oWR_ACK
//   oWR_ACK                 one-cycle pulse when the write is accepted
//   iRD_REQ/ADDR            read request, held stable until oRD_ACK
//   oRD_ACK                 one-cycle pulse when the read is accepted
//   oRD_DATA, oRD_VALID     captured read word, one-cycle update strobe
//   oBUSY                   access in progress
//   ioSRAM_DQ               SRAM data bus, driven only while writing
//   oSRAM_ADDR/CE_N/OE_N/WE_N/BE_N  SRAM address and active-low strobes
module sram_arbiter_ctrl #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 0,
  parameter int ARB_MODE    = 0,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iWR_REQ,
  input  logic [ADDR_W-1:0] iWR_ADDR,
  input  logic [DATA_W-1:0] iWR_DATA,
  input  logic [BE_W-1:0]   iWR_BE,
  output logic              oWR_ACK,
  input  logic              iRD_REQ,
  input  logic [ADDR_W-1:0] iRD_ADDR,
  output logic              oRD_ACK,
  output logic [DATA_W-1:0] oRD_DATA,
  output logic              oRD_VALID,
  output logic              oBUSY,
  inout  wire  [DATA_W-1:0] ioSRAM_DQ,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  output logic              oSRAM_CE_N,
  output logic              oSRAM_OE_N,
  output logic              oSRAM_WE_N,
  output logic [BE_W-1:0]   oSRAM_BE_N
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t            state, stateNext;
  logic [3:0]        waitCnt;
  logic              lastWr;     // 1 = last grant went to the write port
  logic              grantWr, grantRd;
  logic              accessEnd;
  logic [DATA_W-1:0] wrData;
  logic              dqOe;

  assign accessEnd = (state != IDLE) && (waitCnt == 4'd0);
  assign oBUSY     = (state != IDLE);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  // Grants are only issued from IDLE, so a held request can never be
  // accepted twice and every access is followed by a turnaround cycle.
  always_comb begin
    stateNext = state;
    grantWr   = 1'b0;
    grantRd   = 1'b0;
    unique case (state)
      IDLE: begin
        if (iWR_REQ && (!iRD_REQ || (ARB_MODE == 0) || !lastWr)) begin
          grantWr   = 1'b1;
          stateNext = WRITE;
        end else if (iRD_REQ) begin
          grantRd   = 1'b1;
          stateNext = READ;
        end
      end
      WRITE, READ: if (waitCnt == 4'd0) stateNext = IDLE;
      default:     stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      waitCnt    <= 4'd0;
      lastWr     <= 1'b0;
      wrData     <= '0;
      dqOe       <= 1'b0;
      oWR_ACK    <= 1'b0;
      oRD_ACK    <= 1'b0;
      oRD_VALID  <= 1'b0;
      oRD_DATA   <= '0;
      oSRAM_ADDR <= '0;
      oSRAM_CE_N <= 1'b1;
      oSRAM_OE_N <= 1'b1;
      oSRAM_WE_N <= 1'b1;
      oSRAM_BE_N <= '1;
    end else begin
      oWR_ACK   <= grantWr;
      oRD_ACK   <= grantRd;
      oRD_VALID <= accessEnd && (state == READ);
      if (accessEnd && (state == READ)) oRD_DATA <= ioSRAM_DQ;

      if (grantWr) begin
        waitCnt    <= WAIT_LD;
        lastWr     <= 1'b1;
        wrData     <= iWR_DATA;
        dqOe       <= 1'b1;
        oSRAM_ADDR <= iWR_ADDR;
        oSRAM_CE_N <= 1'b0;
        oSRAM_OE_N <= 1'b1;
        oSRAM_WE_N <= 1'b0;
        oSRAM_BE_N <= ~iWR_BE;
      end else if (grantRd) begin
        waitCnt    <= WAIT_LD;
        lastWr     <= 1'b0;
        dqOe       <= 1'b0;
        oSRAM_ADDR <= iRD_ADDR;
        oSRAM_CE_N <= 1'b0;
        oSRAM_OE_N <= 1'b0;
        oSRAM_WE_N <= 1'b1;
        oSRAM_BE_N <= '0;
      end else if (accessEnd) begin
        // Strobes drop with the return to IDLE; address is left as-is.
        dqOe       <= 1'b0;
        oSRAM_CE_N <= 1'b1;
        oSRAM_OE_N <= 1'b1;
        oSRAM_WE_N <= 1'b1;
        oSRAM_BE_N <= '1;
      end else if (state != IDLE) begin
        waitCnt <= waitCnt - 4'd1;
      end
    end
  end

  // Byte-lane bus drivers.
  for (genvar i = 0; i < BE_W; i++) begin : gLane
    assign ioSRAM_DQ[8*i +: 8] = dqOe ? wrData[8*i +: 8] : 8'bz;
  end

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Directed bench for sram_arbiter_ctrl. Three instances with different
// WAIT_CYCLES / ARB_MODE settings, each with its own behavioural SRAM.
//   [0] WAIT_CYCLES=0 ARB_MODE=1   [1] WAIT_CYCLES=3 ARB_MODE=0
//   [2] WAIT_CYCLES=2 ARB_MODE=0
module tb_sram_arbiter_ctrl;

  logic iCLK = 1'b0;
  logic rst;
  always #5 iCLK = ~iCLK;

  logic [2:0]        wrReq, rdReq;
  logic [2:0][19:0]  wrAddr, rdAddr;
  logic [2:0][15:0]  wrData;
  logic [2:0][1:0]   wrBe;
  wire  [2:0]        wrAck, rdAck, rdValid, busy, ceN, oeN, weN;
  wire  [2:0][15:0]  rdData, dqObs;
  wire  [2:0][19:0]  sAddr;
  wire  [2:0][1:0]   beN;

  int nCmp = 0;
  int nErr = 0;

  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int WC = (g == 0) ? 0 : (g == 1) ? 3 : 2;
    localparam int AM = (g == 0) ? 1 : 0;
    wire  [15:0] dq;
    logic [15:0] mem [256];

    assign dqObs[g] = dq;
    // Asynchronous SRAM: drives the bus while selected and output-enabled.
    assign dq = (!ceN[g] && !oeN[g] && weN[g]) ? mem[sAddr[g][7:0]] : 16'bz;
    always @(negedge iCLK) begin
      if (!ceN[g] && !weN[g]) begin
        if (!beN[g][0]) mem[sAddr[g][7:0]][7:0]  <= dq[7:0];
        if (!beN[g][1]) mem[sAddr[g][7:0]][15:8] <= dq[15:8];
      end
    end

    sram_arbiter_ctrl #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(WC), .ARB_MODE(AM)) uDut (
      .iCLK(iCLK), .iRST(rst),
      .iWR_REQ(wrReq[g]), .iWR_ADDR(wrAddr[g]), .iWR_DATA(wrData[g]), .iWR_BE(wrBe[g]),
      .oWR_ACK(wrAck[g]),
      .iRD_REQ(rdReq[g]), .iRD_ADDR(rdAddr[g]), .oRD_ACK(rdAck[g]),
      .oRD_DATA(rdData[g]), .oRD_VALID(rdValid[g]), .oBUSY(busy[g]),
      .ioSRAM_DQ(dq), .oSRAM_ADDR(sAddr[g]),
      .oSRAM_CE_N(ceN[g]), .oSRAM_OE_N(oeN[g]), .oSRAM_WE_N(weN[g]), .oSRAM_BE_N(beN[g])
    );
  end

  task automatic tick;
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, na, nr, nv;
    logic [1:0] rrExp;
    wrReq = '0; rdReq = '0; wrAddr = '0; rdAddr = '0; wrData = '0; wrBe = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    // Reset values appear before any clock edge.
    chk("rst_pulses", 32'({wrAck, rdAck, rdValid, busy}), 32'h0);
    chk("rst_strobes", 32'({ceN, oeN, weN}), 32'h1FF);
    chk("rst_beN", 32'(beN), 32'h3F);
    chk("rst_addr", 32'(sAddr[0]), 32'h0);
    chk("rst_rdData", 32'(rdData[0]), 32'h0);

    // Request pending across reset and its release.
    wrReq[0] = 1'b1; wrAddr[0] = 20'h00123; wrData[0] = 16'hBEEF; wrBe[0] = 2'b11;
    tick; tick;
    chk("rst_held_noack", 32'(wrAck[0]), 32'h0);
    rst = 1'b0;
    chk("rst_release_noack", 32'(wrAck[0]), 32'h0);

    // Single write, WAIT_CYCLES=0.
    tick;
    chk("w0_ack", 32'(wrAck[0]), 32'h1);
    chk("w0_strobes", 32'({ceN[0], oeN[0], weN[0]}), 32'b010);
    chk("w0_addr", 32'(sAddr[0]), 32'h00123);
    chk("w0_dq", 32'(dqObs[0]), 32'hBEEF);
    chk("w0_beN", 32'(beN[0]), 32'h0);
    chk("w0_busy", 32'(busy[0]), 32'h1);
    wrReq[0] = 1'b0;
    tick;
    chk("w0_ack_end", 32'(wrAck[0]), 32'h0);
    chk("w0_strobes_end", 32'({ceN[0], oeN[0], weN[0]}), 32'b111);
    chk("w0_busy_end", 32'(busy[0]), 32'h0);
    chk("w0_addr_hold", 32'(sAddr[0]), 32'h00123);

    // Readback.
    rdReq[0] = 1'b1; rdAddr[0] = 20'h00123;
    tick;
    chk("r0_ack", 32'(rdAck[0]), 32'h1);
    chk("r0_strobes", 32'({ceN[0], oeN[0], weN[0]}), 32'b001);
    chk("r0_beN", 32'(beN[0]), 32'h0);
    chk("r0_valid_early", 32'(rdValid[0]), 32'h0);
    rdReq[0] = 1'b0;
    tick;
    chk("r0_valid", 32'(rdValid[0]), 32'h1);
    chk("r0_data", 32'(rdData[0]), 32'hBEEF);
    chk("r0_oe_end", 32'(oeN[0]), 32'h1);
    tick;
    chk("r0_valid_end", 32'(rdValid[0]), 32'h0);
    chk("r0_data_hold", 32'(rdData[0]), 32'hBEEF);

    // Round-robin with both requests held: W,-,R,-,W,-,R,-.
    wrReq[0] = 1'b1; rdReq[0] = 1'b1; wrAddr[0] = 20'h00010; wrData[0] = 16'h1111;
    for (int i = 0; i < 8; i++) begin
      tick;
      rrExp = (i % 4 == 0) ? 2'b10 : (i % 4 == 2) ? 2'b01 : 2'b00;
      chk($sformatf("rr_acks_%0d", i), 32'({wrAck[0], rdAck[0]}), 32'(rrExp));
    end
    wrReq[0] = 1'b0; rdReq[0] = 1'b0;
    tick; tick;

    // Byte enables, WAIT_CYCLES=3: two back-to-back writes, period 5.
    wrReq[1] = 1'b1; wrAddr[1] = 20'h00055; wrData[1] = 16'h1234; wrBe[1] = 2'b11;
    tick;
    chk("be_w1_ack", 32'(wrAck[1]), 32'h1);
    chk("be_w1_we", 32'(weN[1]), 32'h0);
    wrData[1] = 16'hABCD; wrBe[1] = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      tick;
      chk($sformatf("be_we_%0d", k), 32'(weN[1]), (k == 4) ? 32'h1 : 32'h0);
      chk($sformatf("be_ack_%0d", k), 32'(wrAck[1]), (k == 5) ? 32'h1 : 32'h0);
    end
    chk("be_w2_beN", 32'(beN[1]), 32'b10);
    chk("be_w2_dq", 32'(dqObs[1]), 32'hABCD);
    wrReq[1] = 1'b0; rdReq[1] = 1'b1; rdAddr[1] = 20'h00055;
    n = 0;
    do begin tick; n++; end while (!rdAck[1] && n < 20);
    chk("be_rd_grant_delay", 32'(n), 32'd5);
    rdReq[1] = 1'b0;
    n = 0;
    do begin tick; n++; end while (!rdValid[1] && n < 20);
    chk("be_rd_latency", 32'(n), 32'd4);
    chk("be_rd_data", 32'(rdData[1]), 32'h12CD);
    tick;

    // Fixed write priority with both requests held.
    wrReq[1] = 1'b1; rdReq[1] = 1'b1; wrAddr[1] = 20'h00060; wrData[1] = 16'h5A5A; wrBe[1] = 2'b11;
    na = 0; nr = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (wrAck[1]) na++;
      if (rdAck[1]) nr++;
    end
    chk("fp_wr_grants", 32'(na), 32'd3);
    chk("fp_rd_grants", 32'(nr), 32'd0);
    wrReq[1] = 1'b0;
    n = 0;
    do begin tick; n++; end while (!rdAck[1] && n < 20);
    chk("fp_rd_after_drop", 32'(n), 32'd4);
    rdReq[1] = 1'b0;
    repeat (6) tick;

    // Reset during C1 of a read, WAIT_CYCLES=2.
    wrReq[2] = 1'b1; wrAddr[2] = 20'h00077; wrData[2] = 16'h0F0F; wrBe[2] = 2'b11;
    tick;
    chk("ar_w_ack", 32'(wrAck[2]), 32'h1);
    wrReq[2] = 1'b0;
    repeat (4) tick;
    rdReq[2] = 1'b1; rdAddr[2] = 20'h00077;
    n = 0;
    do begin tick; n++; end while (!rdAck[2] && n < 20);
    chk("ar_r_ack", 32'(rdAck[2]), 32'h1);
    chk("ar_r_oe", 32'(oeN[2]), 32'h0);
    rdReq[2] = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_strobes", 32'({ceN[2], oeN[2], weN[2]}), 32'b111);
    chk("ar_busy", 32'(busy[2]), 32'h0);
    chk("ar_ack", 32'(rdAck[2]), 32'h0);
    tick;
    rst = 1'b0;
    nv = 0;
    repeat (6) begin tick; if (rdValid[2]) nv++; end
    chk("ar_no_valid", 32'(nv), 32'd0);
    chk("ar_rdData_reset", 32'(rdData[2]), 32'h0);
    rdReq[2] = 1'b1;
    n = 0;
    do begin tick; n++; end while (!rdAck[2] && n < 20);
    chk("ar_r2_ack", 32'(rdAck[2]), 32'h1);
    rdReq[2] = 1'b0;
    n = 0;
    do begin tick; n++; end while (!rdValid[2] && n < 20);
    chk("ar_r2_latency", 32'(n), 32'd3);
    chk("ar_r2_data", 32'(rdData[2]), 32'h0F0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
